// File: rtl/fir_stream_engine_pkg.sv
// Shared definitions for the FIR stream engine.
//   state_t        : control FSM state encoding
//   TAP_STRIDE     : byte distance between consecutive 32-bit taps in the tap RAM
//   tap_byte_addr  : tap index -> tap RAM byte address
package fir_stream_engine_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CALC = 3'd2,
        S_OUT  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int TAP_STRIDE = 4;

    function automatic int tap_byte_addr(input int k);
        return k * TAP_STRIDE;
    endfunction

endpackage

// File: rtl/fir_stream_engine_multiplier_adder.sv
// Combinational multiply-accumulate step: sum_out = sum_in + in1 * in2.
// The product and the sum are both truncated to pWIDTH bits, so the
// result wraps modulo 2^pWIDTH and is signedness agnostic.
//   in1, in2 : multiplicands (tap coefficient, history sample)
//   sum_in   : running accumulator value
//   sum_out  : updated accumulator value
module multiplier_adder #(
    parameter int pWIDTH = 32
) (
    input  logic [pWIDTH-1:0] in1,
    input  logic [pWIDTH-1:0] in2,
    input  logic [pWIDTH-1:0] sum_in,
    output logic [pWIDTH-1:0] sum_out
);

    // Every operand is pWIDTH wide, so the product is sized to pWIDTH and
    // its upper half is dropped.
    assign sum_out = sum_in + in1 * in2;

endmodule

// File: rtl/fir_stream_engine.sv
// Sequential FIR datapath between an AXI-Stream input and output.
// One sample is accepted per input handshake into a pTAP_NUM-deep history,
// then the tap RAM is walked one coefficient per cycle through a single
// MAC, and the result is offered on the output stream. ap_done pulses once
// data_length results have been delivered.
//   axis_clk, axis_rst_n            : clock, synchronous active-low reset
//   ap_start, data_length           : run control in; ap_idle, ap_done out
//   tap_EN, tap_A, tap_Do           : tap RAM read port (1-cycle read latency)
//   ss_tvalid/tdata/tlast/tready    : input sample stream
//   sm_tvalid/tdata/tlast/tready    : output result stream
module fir_stream_engine
    import fir_stream_engine_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int pADDR_WIDTH = 12,
    parameter int pTAP_NUM    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   ap_start,
    input  logic [31:0]            data_length,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic                   ss_tvalid,
    input  logic [pDATA_WIDTH-1:0] ss_tdata,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    output logic [pDATA_WIDTH-1:0] sm_tdata,
    output logic                   sm_tlast,
    input  logic                   sm_tready
);

    localparam int J_W = $clog2(pTAP_NUM + 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(pTAP_NUM);

    state_t                 state;
    logic [J_W-1:0]         j;
    logic [pDATA_WIDTH-1:0] hist [pTAP_NUM];
    logic [pDATA_WIDTH-1:0] acc;
    logic [pDATA_WIDTH-1:0] mac_x;
    logic [pDATA_WIDTH-1:0] mac_sum;
    logic [31:0]            len;
    logic [31:0]            count;
    logic [31:0]            count_next;

    // ss_tlast is accepted with the sample but never steers control.
    logic unused_tlast;
    assign unused_tlast = ss_tlast;

    assign count_next = count + 32'd1;
    assign sm_tdata   = acc;

    // In CALC step j the tap RAM returns h[j-1], so pair it with x[j-1].
    // NOTE: give every always_comb output a default first; a path that
    // leaves it unassigned would infer a latch.
    always_comb begin
        mac_x = '0;
        for (int k = 1; k <= pTAP_NUM; k++) begin
            if (int'(j) == k) mac_x = hist[k-1];
        end
    end

    multiplier_adder #(
        .pWIDTH (pDATA_WIDTH)
    ) u_mac (
        .in1     (tap_Do),
        .in2     (mac_x),
        .sum_in  (acc),
        .sum_out (mac_sum)
    );

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            state     <= S_IDLE;
            j         <= '0;
            acc       <= '0;
            len       <= '0;
            count     <= '0;
            ap_idle   <= 1'b1;
            ap_done   <= 1'b0;
            tap_EN    <= 1'b0;
            tap_A     <= '0;
            ss_tready <= 1'b0;
            sm_tvalid <= 1'b0;
            sm_tlast  <= 1'b0;
            // NOTE: the history is a small register array, not a RAM, and it
            // must read as zero before the first samples arrive, so it is reset.
            for (int k = 0; k < pTAP_NUM; k++) hist[k] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ap_start) begin
                        len     <= data_length;
                        count   <= '0;
                        ap_idle <= 1'b0;
                        for (int k = 0; k < pTAP_NUM; k++) hist[k] <= '0;
                        if (data_length == '0) begin
                            state   <= S_DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state     <= S_LOAD;
                            ss_tready <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    // ss_tready is high for the whole of LOAD.
                    if (ss_tvalid) begin
                        for (int k = pTAP_NUM - 1; k > 0; k--) hist[k] <= hist[k-1];
                        hist[0]   <= ss_tdata;
                        acc       <= '0;
                        j         <= '0;
                        tap_EN    <= 1'b1;
                        tap_A     <= '0;
                        ss_tready <= 1'b0;
                        state     <= S_CALC;
                    end
                end

                S_CALC: begin
                    if (j != '0) acc <= mac_sum;
                    if (j == J_LAST) begin
                        state     <= S_OUT;
                        sm_tvalid <= 1'b1;
                        sm_tlast  <= (count_next == len);
                    end else begin
                        j <= j + 1'b1;
                        // Address for step j+1 is registered now; the last
                        // step (j = N) only consumes the final read.
                        if (int'(j) + 1 < pTAP_NUM) begin
                            tap_EN <= 1'b1;
                            tap_A  <= pADDR_WIDTH'(tap_byte_addr(int'(j) + 1));
                        end else begin
                            tap_EN <= 1'b0;
                            tap_A  <= '0;
                        end
                    end
                end

                S_OUT: begin
                    if (sm_tready) begin
                        count     <= count_next;
                        sm_tvalid <= 1'b0;
                        sm_tlast  <= 1'b0;
                        if (count_next == len) begin
                            state   <= S_DONE;
                            ap_done <= 1'b1;
                        end else begin
                            state     <= S_LOAD;
                            ss_tready <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    ap_done <= 1'b0;
                    ap_idle <= 1'b1;
                    state   <= S_IDLE;
                end

                default: begin
                    state   <= S_IDLE;
                    ap_idle <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream_engine.sv
// Scoreboard bench for fir_stream_engine: stimulus pushes the expected
// result (direct convolution of the run's samples with the taps) and a
// negedge monitor pops and compares on each output handshake.
module tb_fir_stream_engine;

    localparam int N  = 11;
    localparam int DW = 32;
    localparam int AW = 12;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n = 1'b0;
    logic          ap_start = 1'b0;
    logic [31:0]   data_length = '0;
    logic          ap_idle, ap_done, tap_EN;
    logic [AW-1:0] tap_A;
    logic [DW-1:0] tap_Do = '0;
    logic          ss_tvalid = 1'b0;
    logic [DW-1:0] ss_tdata = '0;
    logic          ss_tlast = 1'b0;
    logic          ss_tready;
    logic          sm_tvalid;
    logic [DW-1:0] sm_tdata;
    logic          sm_tlast;
    logic          sm_tready = 1'b1;

    always #5 axis_clk = ~axis_clk;

    fir_stream_engine #(
        .pDATA_WIDTH (DW),
        .pADDR_WIDTH (AW),
        .pTAP_NUM    (N)
    ) dut (
        .axis_clk    (axis_clk),
        .axis_rst_n  (axis_rst_n),
        .ap_start    (ap_start),
        .data_length (data_length),
        .ap_idle     (ap_idle),
        .ap_done     (ap_done),
        .tap_EN      (tap_EN),
        .tap_A       (tap_A),
        .tap_Do      (tap_Do),
        .ss_tvalid   (ss_tvalid),
        .ss_tdata    (ss_tdata),
        .ss_tlast    (ss_tlast),
        .ss_tready   (ss_tready),
        .sm_tvalid   (sm_tvalid),
        .sm_tdata    (sm_tdata),
        .sm_tlast    (sm_tlast),
        .sm_tready   (sm_tready)
    );

    // Tap RAM: registered read, byte addressed.
    logic [31:0] coef [N];
    always @(posedge axis_clk) begin
        if (tap_EN) tap_Do <= (int'(tap_A) / 4 < N) ? coef[int'(tap_A) / 4] : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          hs_edge;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge axis_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- output backpressure driver ----------------
    int   stall_next_out = 0;
    int   stall_rand_max = 0;
    int   stall_left = 0;
    logic v_seen = 1'b0;

    always @(posedge axis_clk) begin
        #1;
        if (!sm_tvalid) begin
            v_seen    = 1'b0;
            sm_tready = 1'b1;
        end else begin
            if (!v_seen) begin
                v_seen         = 1'b1;
                stall_left     = stall_next_out +
                                 ((stall_rand_max > 0) ? int'($urandom_range(0, stall_rand_max)) : 0);
                stall_next_out = 0;
            end
            if (stall_left > 0) begin
                sm_tready = 1'b0;
                stall_left--;
            end else begin
                sm_tready = 1'b1;
            end
        end
    end

    // ---------------- monitor ----------------
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_data = '0;
    int          done_seen = 0;
    int          ss_hs = 0;
    int          sm_hs = 0;
    int          expect_done_edge = -1;
    int          expect_idle_edge = -1;

    always @(negedge axis_clk) begin
        exp_t e;
        if (axis_rst_n) begin
            if (ss_tvalid && ss_tready) ss_hs++;
            if (sm_tvalid && !prev_valid && sb.size() > 0)
                check("out_latency", 32'(cyc + 1), 32'(sb[0].hs_edge + N + 2));
            if (sm_tvalid && prev_valid && !prev_ready) begin
                check("stall_data_stable", sm_tdata, prev_data);
                check("stall_ss_tready_low", {31'd0, ss_tready}, 32'd0);
            end
            if (sm_tvalid && sm_tready) begin
                sm_hs++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h expected none", sm_tdata);
                end else begin
                    e = sb.pop_front();
                    if (sm_tdata !== e.data || sm_tlast !== e.last) begin
                        errors++;
                        $display("FAIL output: got data %h last %b expected data %h last %b",
                                 sm_tdata, sm_tlast, e.data, e.last);
                    end
                    if (e.last) expect_done_edge = cyc + 1;
                end
            end
            if (ap_done) begin
                done_seen++;
                if (expect_done_edge >= 0) begin
                    check("ap_done_timing", 32'(cyc), 32'(expect_done_edge));
                    expect_idle_edge = cyc + 1;
                    expect_done_edge = -1;
                end
            end
            if (expect_idle_edge >= 0 && cyc == expect_idle_edge) begin
                check("ap_idle_after_done", {31'd0, ap_idle}, 32'd1);
                expect_idle_edge = -1;
            end
        end
        prev_valid = sm_tvalid & axis_rst_n;
        prev_ready = sm_tready;
        prev_data  = sm_tdata;
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle();
        int t = 0;
        while (ap_idle !== 1'b1 && t < 500) begin
            @(posedge axis_clk); #1;
            t++;
        end
        if (t >= 500) check("wait_idle_timeout", {31'd0, ap_idle}, 32'd1);
    endtask

    task automatic start(input int len);
        ap_start    = 1'b1;
        data_length = 32'(len);
        @(posedge axis_clk); #1;
        ap_start    = 1'b0;
        data_length = $urandom;
    endtask

    task automatic send(input logic [31:0] x, input int gap, input logic [31:0] y, input logic last);
        exp_t e;
        int   t = 0;
        repeat (gap) begin
            @(posedge axis_clk); #1;
        end
        ss_tvalid = 1'b1;
        ss_tdata  = x;
        ss_tlast  = last;
        forever begin
            @(negedge axis_clk);
            if (ss_tready) break;
            t++;
            if (t > 500) begin
                check("ss_tready_timeout", {31'd0, ss_tready}, 32'd1);
                ss_tvalid = 1'b0;
                return;
            end
        end
        e.data    = y;
        e.last    = last;
        e.hs_edge = cyc + 1;
        sb.push_back(e);
        @(posedge axis_clk); #1;
        ss_tvalid = 1'b0;
        ss_tlast  = 1'b0;
        ss_tdata  = $urandom;
    endtask

    // Expected y[n] = sum_k h[k] * x[n-k] (mod 2^32), x taken as zero before
    // the first sample of the run.
    task automatic run(input int len, input logic [31:0] xs[$], input int gap_max,
                       input logic poke_start);
        logic [31:0] past[$];
        logic [31:0] y;
        int          done0;
        int          t;
        wait_idle();
        done0 = done_seen;
        start(len);
        for (int n = 0; n < len; n++) begin
            past.push_front(xs[n]);
            y = '0;
            for (int k = 0; k < N && k < past.size(); k++) y += coef[k] * past[k];
            send(xs[n], (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0, y, n == len - 1);
            if (poke_start && n == 0) begin
                // Engine is in CALC now; this start must be ignored.
                ap_start    = 1'b1;
                data_length = 32'd7;
                @(posedge axis_clk); #1;
                ap_start    = 1'b0;
            end
        end
        t = 0;
        while (done_seen == done0 && t < 2000) begin
            @(posedge axis_clk); #1;
            t++;
        end
        repeat (3) begin
            @(posedge axis_clk); #1;
        end
        check("run_done_count", 32'(done_seen - done0), 32'd1);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] xs[$];
        int          done0, ss0, sm0, t;

        repeat (3) @(posedge axis_clk);
        #1;
        check("rst_ap_idle",   {31'd0, ap_idle},   32'd1);
        check("rst_ap_done",   {31'd0, ap_done},   32'd0);
        check("rst_ss_tready", {31'd0, ss_tready}, 32'd0);
        check("rst_sm_tvalid", {31'd0, sm_tvalid}, 32'd0);
        check("rst_sm_tlast",  {31'd0, sm_tlast},  32'd0);
        check("rst_sm_tdata",  sm_tdata,           32'd0);
        check("rst_tap_en",    {31'd0, tap_EN},    32'd0);
        check("rst_tap_a",     32'(tap_A),         32'd0);
        axis_rst_n = 1'b1;
        @(posedge axis_clk); #1;

        // Impulse response: h[k] = k+1, outputs 1..11 then 0.
        for (int k = 0; k < N; k++) coef[k] = 32'(k + 1);
        xs = {};
        for (int n = 0; n < 12; n++) xs.push_back((n == 0) ? 32'd1 : 32'd0);
        run(12, xs, 0, 1'b0);

        // Short run with a stray ap_start during CALC: outputs 10, 15, 20.
        for (int k = 0; k < N; k++) coef[k] = '0;
        coef[0] = 32'd2; coef[1] = 32'd3; coef[2] = 32'd4;
        xs = {32'd5, 32'd0, 32'd0};
        run(3, xs, 0, 1'b1);

        // Same run with output 1 stalled for 5 cycles.
        stall_next_out = 5;
        run(3, xs, 0, 1'b0);

        // Wrap: 0xFFFF_FFFF * 2 -> 0xFFFF_FFFE.
        for (int k = 0; k < N; k++) coef[k] = '0;
        coef[0] = 32'hFFFF_FFFF;
        xs = {32'd2};
        run(1, xs, 0, 1'b0);

        // Randomized runs with input gaps and output stalls.
        stall_rand_max = 3;
        for (int r = 0; r < 4; r++) begin
            int len;
            for (int k = 0; k < N; k++) coef[k] = $urandom;
            len = $urandom_range(1, 16);
            xs = {};
            for (int n = 0; n < len; n++) xs.push_back($urandom);
            run(len, xs, 3, 1'b0);
        end
        stall_rand_max = 0;

        // data_length = 0: ap_done pulse, no stream traffic.
        wait_idle();
        done0 = done_seen; ss0 = ss_hs; sm0 = sm_hs;
        start(0);
        t = 0;
        while (done_seen == done0 && t < 50) begin
            @(posedge axis_clk); #1;
            t++;
        end
        repeat (3) begin
            @(posedge axis_clk); #1;
        end
        check("zero_len_done",  32'(done_seen - done0), 32'd1);
        check("zero_len_no_ss", 32'(ss_hs - ss0),       32'd0);
        check("zero_len_no_sm", 32'(sm_hs - sm0),       32'd0);
        check("zero_len_idle",  {31'd0, ap_idle},       32'd1);

        // Reset in the middle of CALC.
        for (int k = 0; k < N; k++) coef[k] = 32'(k + 1);
        wait_idle();
        done0 = done_seen;
        start(12);
        send(32'd1, 0, 32'd1, 1'b0);
        @(posedge axis_clk); #1;
        check("mid_calc_tap_en", {31'd0, tap_EN}, 32'd1);
        axis_rst_n = 1'b0;
        @(posedge axis_clk); #1;
        check("mrst_ap_idle",   {31'd0, ap_idle},   32'd1);
        check("mrst_ap_done",   {31'd0, ap_done},   32'd0);
        check("mrst_ss_tready", {31'd0, ss_tready}, 32'd0);
        check("mrst_sm_tvalid", {31'd0, sm_tvalid}, 32'd0);
        check("mrst_sm_tlast",  {31'd0, sm_tlast},  32'd0);
        check("mrst_sm_tdata",  sm_tdata,           32'd0);
        check("mrst_tap_en",    {31'd0, tap_EN},    32'd0);
        check("mrst_tap_a",     32'(tap_A),         32'd0);
        axis_rst_n = 1'b1;
        sb.delete();
        expect_done_edge = -1;
        repeat (30) begin
            @(posedge axis_clk); #1;
        end
        check("mrst_no_done", 32'(done_seen - done0), 32'd0);

        xs = {};
        for (int n = 0; n < 12; n++) xs.push_back((n == 0) ? 32'd1 : 32'd0);
        run(12, xs, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
